// File: rtl/menu_state_control_if.sv
// Menu control bus: enable and key levels toward the menu FSM, registered
// navigation state, cursor, latched selection and launch pulse back out.
// The master drives start/movement; the slave is the menu controller.
interface menu_state_control_if #(
  parameter int IDX_W = 2
);
  logic             start;
  logic [4:0]       movement;
  logic [1:0]       state;
  logic [IDX_W-1:0] cursor;
  logic [IDX_W-1:0] selection;
  logic             launch;

  modport master (
    output start,
    output movement,
    input  state,
    input  cursor,
    input  selection,
    input  launch
  );

  modport slave (
    input  start,
    input  movement,
    output state,
    output cursor,
    output selection,
    output launch
  );
endinterface

// File: rtl/menu_state_control.sv
// menu_state_control: N-item menu navigation FSM.
// States: IDLE -> BROWSE -> (CONFIRM) -> LAUNCHED, forced back to IDLE
// whenever start is low. Keys are edge-detected against the previous cycle's
// levels; select beats down beats up. Items flagged in CONFIRM_MASK pass
// through a confirmation dialog before launch.
// Optional feature: define MENU_AUTOREPEAT_EN to make a held up/down key
// auto-repeat in BROWSE after REPEAT_DELAY cycles, then every REPEAT_PERIOD.
module menu_state_control #(
  parameter int          NUM_ITEMS     = 4,
  parameter int          IDX_W         = 2,
  parameter logic [15:0] CONFIRM_MASK  = 16'h0002,
  parameter bit          WRAP          = 1'b1,
  parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd1_500_000
) (
  input  logic                 clk,
  input  logic                 rst,
  menu_state_control_if.slave  menu
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    BROWSE   = 2'b01,
    CONFIRM  = 2'b10,
    LAUNCHED = 2'b11
  } state_t;

  // Bit positions inside movement; bit 2 carries no meaning here.
  localparam int K_UP   = 0;
  localparam int K_BACK = 1;
  localparam int K_DOWN = 3;
  localparam int K_SEL  = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ITEMS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cursor_q, cursor_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             launch_q, launch_d;
  logic [4:0]       prev_q;
  logic [4:0]       key_ev;
  logic             ev_sel, ev_back, ev_up, ev_down;
  logic             confirm_needed;

  // Rising-edge events relative to the previous cycle's key levels.
  assign key_ev  = menu.movement & ~prev_q;
  assign ev_sel  = key_ev[K_SEL];
  assign ev_back = key_ev[K_BACK];

  // Confirmation requirement of the highlighted item.
  assign confirm_needed = |(CONFIRM_MASK & (16'd1 << cursor_q));

`ifdef MENU_AUTOREPEAT_EN
  logic [23:0] rep_cnt_q;
  logic        rep_armed_q;
  logic        hold_alone;
  logic        rep_fire;
  logic        unused_bits;

  // Up or down held on its own (no edge this cycle) while browsing.
  assign hold_alone = menu.start && (state_q == BROWSE)
                   && !menu.movement[K_SEL] && !menu.movement[K_BACK]
                   && ((menu.movement[K_DOWN] && !menu.movement[K_UP] && prev_q[K_DOWN])
                    || (menu.movement[K_UP] && !menu.movement[K_DOWN] && prev_q[K_UP]));

  // First repeat after the initial delay, later ones after the period.
  assign rep_fire = hold_alone
                 && (rep_cnt_q == (rep_armed_q ? REPEAT_PERIOD - 24'd1
                                               : REPEAT_DELAY - 24'd1));

  assign ev_down = key_ev[K_DOWN] | (rep_fire & menu.movement[K_DOWN]);
  assign ev_up   = key_ev[K_UP]   | (rep_fire & menu.movement[K_UP]);

  // Hold counter: clears on release, key change or leaving BROWSE.
  always_ff @(posedge clk) begin
    if (rst || !hold_alone) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_q + 24'd1;
    end
  end

  assign unused_bits = key_ev[2];
`else
  logic unused_bits;

  assign ev_down     = key_ev[K_DOWN];
  assign ev_up       = key_ev[K_UP];
  assign unused_bits = key_ev[2] ^ (^REPEAT_DELAY) ^ (^REPEAT_PERIOD);
`endif

  // Cursor step toward higher indices, wrapping or saturating at the end.
  function automatic logic [IDX_W-1:0] step_down(input logic [IDX_W-1:0] c);
    if (c == LAST_IDX) return WRAP ? '0 : c;
    return c + IDX_W'(1);
  endfunction

  // Cursor step toward index 0, wrapping or saturating at the start.
  function automatic logic [IDX_W-1:0] step_up(input logic [IDX_W-1:0] c);
    if (c == '0) return WRAP ? LAST_IDX : c;
    return c - IDX_W'(1);
  endfunction

  // Next-state, cursor, selection and launch decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and infers a latch.
    state_d  = state_q;
    cursor_d = cursor_q;
    sel_d    = sel_q;
    launch_d = 1'b0;

    if (!menu.start) begin
      state_d  = IDLE;
      cursor_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = BROWSE;
          cursor_d = '0;
        end
        BROWSE: begin
          if (ev_sel) begin
            if (confirm_needed) begin
              state_d = CONFIRM;
            end else begin
              state_d = LAUNCHED;
              sel_d   = cursor_q;
            end
          end else if (ev_down) begin
            cursor_d = step_down(cursor_q);
          end else if (ev_up) begin
            cursor_d = step_up(cursor_q);
          end
        end
        CONFIRM: begin
          if (ev_sel) begin
            state_d = LAUNCHED;
            sel_d   = cursor_q;
          end else if (ev_back) begin
            state_d = BROWSE;
          end
        end
        LAUNCHED: begin
          state_d = LAUNCHED;
        end
        default: begin
          state_d  = IDLE;
          cursor_d = '0;
        end
      endcase
    end

    // Pulse only on the transition into LAUNCHED.
    launch_d = (state_d == LAUNCHED) && (state_q != LAUNCHED);
  end

  // State registers; the key history updates in every state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= IDLE;
      cursor_q <= '0;
      sel_q    <= '0;
      launch_q <= 1'b0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      sel_q    <= sel_d;
      launch_q <= launch_d;
      prev_q   <= menu.movement;
    end
  end

  assign menu.state     = state_q;
  assign menu.cursor    = cursor_q;
  assign menu.selection = sel_q;
  assign menu.launch    = launch_q;

endmodule

// File: doc/menu_state_control.md
# menu_state_control

Parametrised menu navigation FSM for front-end screens: a cursor over `NUM_ITEMS` entries, optional per-item confirmation dialog, and a one-cycle launch pulse toward the game-state logic. It sits between the keypad/movement decoder and the screen renderer and game-start logic. It generalises the two-choice welcome controller to N items, selectable wrap-around, and edge-detected input.

## Interface
Parameters:
- `NUM_ITEMS`, default 4: number of menu entries, 2..16.
- `IDX_W`, default 2: cursor width; must satisfy 2^IDX_W >= NUM_ITEMS.
- `CONFIRM_MASK`, default 16'h0002: bit i set means item i requires the confirmation dialog before launch.
- `WRAP`, default 1: 1 means the cursor wraps at the ends; 0 means it saturates.
- `REPEAT_DELAY`, default 24'd5_000_000: hold cycles before the first auto-repeat (only with the macro defined).
- `REPEAT_PERIOD`, default 24'd1_500_000: cycles between subsequent repeats (only with the macro defined).

Ports:
- `clk` in 1: system clock. The block uses one clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: menu enable. When low, the block is forced to IDLE.
- `movement` in 5: already synchronised key levels. [4] select, [3] down, [1] back, [0] up; [2] ignored.
- `state` out 2: 00 IDLE, 01 BROWSE, 10 CONFIRM, 11 LAUNCHED.
- `cursor` out IDX_W: index of the highlighted item.
- `selection` out IDX_W: index latched on entry to LAUNCHED.
- `launch` out 1: one-cycle pulse on entry to LAUNCHED.

## Operation
- Edge detection: a register `prev` holds the last `movement` value and updates every cycle, in every state. An event is `movement & ~prev`. A key already held when `start` rises produces no event.
- IDLE: if `start`=1, go to BROWSE next cycle; `cursor` stays 0.
- BROWSE, event priority select > down > up, one action per cycle:
  - select on item c with CONFIRM_MASK[c]=1: go to CONFIRM.
  - select on item c with CONFIRM_MASK[c]=0: go to LAUNCHED, set `selection`=c, pulse `launch`.
  - down: `cursor`+1. At NUM_ITEMS-1 it goes to 0 if WRAP=1, otherwise it holds.
  - up: `cursor`-1. At 0 it goes to NUM_ITEMS-1 if WRAP=1, otherwise it holds.
  - back: ignored.
- CONFIRM:
  - select: go to LAUNCHED, set `selection`=`cursor`, pulse `launch`.
  - back: go to BROWSE, `cursor` unchanged.
  - select and back together: select wins.
  - up/down: ignored.
- LAUNCHED: all events ignored. The block holds until `start` falls.
- `start`=0 in any state: next state IDLE, `cursor`=0. `selection` holds its value. `launch` is not asserted.
- Width rules: cursor arithmetic is modulo NUM_ITEMS, not 2^IDX_W. Cursor values >= NUM_ITEMS never appear.

## Timing
- Reset values: `state`=00, `cursor`=0, `selection`=0, `launch`=0, `prev`=0, repeat counter=0.
- All outputs are registered. A key edge sampled at posedge k is reflected in the outputs after posedge k (1-cycle latency from the input change).
- `launch` is high for exactly the first cycle in which `state`=11.
- Priority: `rst` over `start`=0 over key events. If `rst` is asserted mid-dialog or mid-repeat, all state clears on the next edge.
- `start` falling in the same cycle as a select event: the block goes to IDLE, with no launch.

## Configuration
- `MENU_AUTOREPEAT_EN` defined: while up or down is held alone in BROWSE, a counter runs.
  - After REPEAT_DELAY cycles the block generates a synthetic event, then one every REPEAT_PERIOD cycles.
  - The counter clears on release, on a change of key, or on leaving BROWSE.
  - Select and back never repeat.
- Not defined: events come from rising edges only. The counter logic and the REPEAT_* parameters are unused.

## Test plan
- Reset, then `start`=1 with no keys: `state` 00 then 01 one cycle later; `cursor`=0, `launch`=0.
- NUM_ITEMS=3, WRAP=1: 3 down pulses give `cursor` 1, 2, 0; then 1 up pulse gives 2. With WRAP=0, 3 downs saturate at 2 and an up at 0 holds 0.
- CONFIRM_MASK=2: on item 1, select gives `state`=10. Back returns to 01 with `cursor`=1. Select then select again gives `state`=11, `selection`=1, and `launch` high for exactly 1 cycle.
- Select held across the `start` rise: no launch. `start` dropped while in LAUNCHED: `state`=00, `cursor`=0, `selection` retained.
- Select and down rising in the same cycle on unmasked item 0: immediate launch with `selection`=0 and `cursor` unchanged.
- With `MENU_AUTOREPEAT_EN`, REPEAT_DELAY=10, REPEAT_PERIOD=4, down held 22 cycles: `cursor` increments at the edge and at cycles +10, +14, +18, +22.
